// File: rtl/wb_fifo_slave_pkg.sv
// Shared constants for wb_fifo_slave: word map, FSM encoding, STATUS/CTRL bit positions.
package wb_fifo_slave_pkg;

  localparam logic [2:0] WORD_DATA    = 3'd0;
  localparam logic [2:0] WORD_STATUS  = 3'd1;
  localparam logic [2:0] WORD_CTRL    = 3'd2;
  localparam logic [2:0] WORD_SCRATCH = 3'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UNF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_WAIT_MSB = 3;
  localparam int CTRL_FLUSH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic unf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_OVF]   = ovf;
    w[STAT_UNF]   = unf;
    w[STAT_CNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/wb_fifo_slave_fifo.sv
// Synchronous byte FIFO with push/pop/flush; push when full and pop when empty are ignored.
module wb_fifo_slave_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // storage array, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s && !rst && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone classic register slave fronting a byte FIFO, with programmable wait states.
// Optional macro WB_FIFO_SLAVE_ERR_EN adds wb_err_o for bad words and FIFO over/underflow.
module wb_fifo_slave
  import wb_fifo_slave_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int WAIT_DEFAULT = 0
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
`ifdef WB_FIFO_SLAVE_ERR_EN
  output logic        wb_err_o,
`endif
  output logic        wb_ack_o
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_r, state_s;
  logic [3:0]    wcnt_r, wait_r;
  logic [2:0]    adr_r;
  logic          we_r;
  logic [3:0]    sel_r;
  logic [31:0]   wdat_r;
  logic [31:0]   scratch_r;
  logic          ovf_r, unf_r;
  logic          ack_r;
  logic [31:0]   dat_r;
  logic          req_s;
  logic [2:0]    cur_adr_s;
  logic          cur_we_s;
  logic [3:0]    cur_sel_s;
  logic [31:0]   rdata_s;
  logic          err_s;
  logic          commit_s, data_acc_s;
  logic          push_s, pop_s, flush_s;
  logic [7:0]    head_s;
  logic [CW-1:0] count_s;
  logic          full_s, empty_s;
  logic          unused_s;

  assign req_s    = wb_cyc_i & wb_stb_i;
  assign unused_s = ^wb_adr_i[1:0];
  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;

  // the request being decided this cycle: live bus in IDLE, latched copy otherwise
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_adr_s = wb_adr_i[4:2];
      cur_we_s  = wb_we_i;
      cur_sel_s = wb_sel_i;
    end else begin
      cur_adr_s = adr_r;
      cur_we_s  = we_r;
      cur_sel_s = sel_r;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) state_s = (wait_r != 4'd0) ? ST_WAIT : ST_ACK;
        else       state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (!req_s)              state_s = ST_IDLE;
        else if (wcnt_r <= 4'd1) state_s = ST_ACK;
        else                     state_s = ST_WAIT;
      end
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // read mux and error decision, evaluated as the FSM enters ACK
  always_comb begin
    rdata_s = 32'd0;
    case (cur_adr_s)
      WORD_DATA:    rdata_s = empty_s ? 32'd0 : {24'd0, head_s};
      WORD_STATUS:  rdata_s = status_word(empty_s, full_s, ovf_r, unf_r, 8'(count_s));
      WORD_CTRL:    rdata_s = {28'd0, wait_r};
      WORD_SCRATCH: rdata_s = scratch_r;
      default:      rdata_s = 32'd0;
    endcase
`ifdef WB_FIFO_SLAVE_ERR_EN
    err_s = cur_adr_s[2] |
            ((cur_adr_s == WORD_DATA) & cur_sel_s[0] & (cur_we_s ? full_s : empty_s));
`else
    err_s = 1'b0;
`endif
  end

  assign commit_s   = (state_r == ST_ACK);
  assign data_acc_s = commit_s & (adr_r == WORD_DATA) & sel_r[0];
  assign push_s     = data_acc_s & we_r & ~full_s;
  assign pop_s      = data_acc_s & ~we_r & ~empty_s;
  assign flush_s    = commit_s & we_r & (adr_r == WORD_CTRL) & sel_r[1] & wdat_r[CTRL_FLUSH];

  // FSM state, wait counter and request capture
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 4'd0;
      adr_r   <= 3'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      wdat_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE) wcnt_r <= wait_r;
      else if (state_r == ST_WAIT) wcnt_r <= wcnt_r - 4'd1;
      if (state_r == ST_IDLE && req_s) begin
        adr_r  <= wb_adr_i[4:2];
        we_r   <= wb_we_i;
        sel_r  <= wb_sel_i;
        wdat_r <= wb_dat_i;
      end
    end
  end

  // registered bus responses; data is forced to zero outside the ack cycle
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= (state_s == ST_ACK) & ~err_s;
      dat_r <= ((state_s == ST_ACK) && !err_s && !cur_we_s) ? rdata_s : 32'd0;
    end
  end

`ifdef WB_FIFO_SLAVE_ERR_EN
  logic err_r;
  assign wb_err_o = err_r;

  // error response replaces ack for the same single cycle
  always_ff @(posedge clk) begin
    if (wb_rst_i) err_r <= 1'b0;
    else          err_r <= (state_s == ST_ACK) & err_s;
  end
`endif

  // register side effects, committed on the edge that ends the ACK cycle
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      wait_r    <= 4'(WAIT_DEFAULT);
      scratch_r <= 32'd0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else if (flush_s) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      if (sel_r[0]) wait_r <= wdat_r[CTRL_WAIT_MSB:0];
    end else begin
      if (data_acc_s && we_r && full_s)   ovf_r <= 1'b1;
      if (data_acc_s && !we_r && empty_s) unf_r <= 1'b1;
      if (commit_s && we_r && adr_r == WORD_CTRL && sel_r[0]) wait_r <= wdat_r[CTRL_WAIT_MSB:0];
      if (commit_s && we_r && adr_r == WORD_SCRATCH) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_r[i]) scratch_r[8*i +: 8] <= wdat_r[8*i +: 8];
        end
      end
    end
  end

  wb_fifo_slave_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (wb_rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (wdat_r[7:0]),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Randomized bench for wb_fifo_slave against a queue-based model of the register map.
// Build with WB_FIFO_SLAVE_ERR_EN defined to exercise the error-response variant.
module tb_wb_fifo_slave;

  localparam int DEPTH        = 16;
  localparam int WAIT_DEFAULT = 0;
`ifdef WB_FIFO_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [4:0]  wb_adr_i = 5'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic        wb_ack_o;
  logic        err_sig;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_fifo_slave #(.DEPTH(DEPTH), .WAIT_DEFAULT(WAIT_DEFAULT)) dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_sel_i (wb_sel_i),
`ifdef WB_FIFO_SLAVE_ERR_EN
    .wb_err_o (err_sig),
`endif
    .wb_ack_o (wb_ack_o)
  );
`ifndef WB_FIFO_SLAVE_ERR_EN
  assign err_sig = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  byte unsigned q[$];
  bit           m_ovf, m_unf;
  int           m_wait;
  logic [31:0]  m_scratch;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_wait = WAIT_DEFAULT;
    m_scratch = 32'd0;
  endtask

  task automatic model_access(input bit we, input int word, input logic [3:0] sel,
                              input logic [31:0] dat, output logic [31:0] rd, output bit err);
    rd = 32'd0;
    err = 1'b0;
    if (word > 3) begin
      err = ERR_EN;
    end else if (word == 0) begin
      if (we) begin
        if (sel[0]) begin
          if (q.size() == DEPTH) begin m_ovf = 1'b1; err = ERR_EN; end
          else q.push_back(dat[7:0]);
        end
      end else if (q.size() == 0) begin
        if (sel[0]) begin m_unf = 1'b1; err = ERR_EN; end
      end else begin
        rd = {24'd0, q[0]};
        if (sel[0]) void'(q.pop_front());
      end
    end else if (word == 1) begin
      if (!we) rd = {16'd0, 8'(q.size()), 4'd0, m_unf, m_ovf,
                     q.size() == DEPTH, q.size() == 0};
    end else if (word == 2) begin
      if (we) begin
        if (sel[0]) m_wait = int'(dat[3:0]);
        if (sel[1] && dat[8]) begin q.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
      end else rd = 32'(m_wait);
    end else begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) m_scratch[8*i +: 8] = dat[8*i +: 8];
      end else rd = m_scratch;
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [2:0] word, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd, output bit ack,
                         output bit err, output int lat, output bit leak, output bit stuck);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {word, 2'($urandom)}; wb_sel_i = sel; wb_dat_i = dat;
    lat = 0; ack = 1'b0; err = 1'b0; rd = 32'd0; leak = 1'b0;
    while (lat < 40 && !ack && !err) begin
      @(posedge clk); #1;
      lat++;
      ack = wb_ack_o;
      err = err_sig;
      rd  = wb_dat_o;
      if (!wb_ack_o && wb_dat_o != 32'd0) leak = 1'b1;
    end
    @(posedge clk); #1;
    stuck = wb_ack_o | err_sig | (wb_dat_o != 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic do_access(input bit we, input logic [2:0] word, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rd, output bit ack,
                           output bit err, output int lat);
    logic [31:0] exp_rd;
    bit          exp_err, leak, stuck;
    int          exp_lat;
    exp_lat = 1 + m_wait;
    model_access(we, int'(word), sel, dat, exp_rd, exp_err);
    wb_xfer(we, word, sel, dat, rd, ack, err, lat, leak, stuck);
    check("handshake", {30'd0, ack, err}, {30'd0, !exp_err, exp_err});
    check("latency", 32'(lat), 32'(exp_lat));
    if (!we) check("rdata", rd, exp_rd);
    check("dat_zero_no_ack", {31'd0, leak}, 32'd0);
    check("single_cycle", {31'd0, stuck}, 32'd0);
  endtask

  logic [31:0] rd;
  bit          ack, err, seen;
  int          lat;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    wb_rst_i = 1'b0;

    // status straight out of reset
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("status_reset", rd, 32'h0000_0001);
    check("status_lat", 32'(lat), 32'd1);

    // push then pop two bytes
    do_access(1'b1, 3'd0, 4'h1, 32'h0000_0081, rd, ack, err, lat);
    do_access(1'b1, 3'd0, 4'h1, 32'hFFFF_FF42, rd, ack, err, lat);
    do_access(1'b0, 3'd0, 4'hF, 32'd0, rd, ack, err, lat);
    check("pop_first", rd, 32'h0000_0081);
    do_access(1'b0, 3'd0, 4'hF, 32'd0, rd, ack, err, lat);
    check("pop_second", rd, 32'h0000_0042);
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("status_empty", rd, 32'h0000_0001);

    // wait states and byte-lane scratch writes
    do_access(1'b1, 3'd2, 4'h1, 32'h0000_0003, rd, ack, err, lat);
    do_access(1'b1, 3'd3, 4'b0101, 32'hA5A5_A5A5, rd, ack, err, lat);
    do_access(1'b0, 3'd3, 4'hF, 32'd0, rd, ack, err, lat);
    check("scratch_lanes", rd, 32'h00A5_00A5);
    check("scratch_lat", 32'(lat), 32'd4);

    // overflow and flush
    do_access(1'b1, 3'd2, 4'h1, 32'h0000_0000, rd, ack, err, lat);
    for (int i = 0; i <= DEPTH; i++)
      do_access(1'b1, 3'd0, 4'h1, 32'($urandom), rd, ack, err, lat);
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("status_full_ovf", rd, {16'd0, 8'(DEPTH), 8'h06});
    do_access(1'b1, 3'd2, 4'h2, 32'h0000_0100, rd, ack, err, lat);
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("status_flushed", rd, 32'h0000_0001);

    // abort by dropping stb mid-wait
    do_access(1'b1, 3'd2, 4'h1, 32'h0000_0003, rd, ack, err, lat);
    do_access(1'b1, 3'd0, 4'h1, 32'h0000_0011, rd, ack, err, lat);
    do_access(1'b1, 3'd0, 4'h1, 32'h0000_0022, rd, ack, err, lat);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd0; wb_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= wb_ack_o | err_sig; end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("abort_count", rd, 32'h0000_0200);

    // reset in the middle of a wait
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd0; wb_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= wb_ack_o | err_sig;
    wb_rst_i = 1'b0;
    model_reset();
    repeat (5) begin @(negedge clk); seen |= wb_ack_o | err_sig; end
    check("rst_wait_no_ack", {31'd0, seen}, 32'd0);
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("rst_wait_status", rd, 32'h0000_0001);

    // unmapped word and underflow
    do_access(1'b0, 3'd5, 4'hF, 32'd0, rd, ack, err, lat);
    check("w5_ack", {31'd0, ack}, {31'd0, !ERR_EN});
    check("w5_err", {31'd0, err}, {31'd0, ERR_EN});
    check("w5_data", rd, 32'd0);
    do_access(1'b0, 3'd0, 4'hF, 32'd0, rd, ack, err, lat);
    check("unf_err", {31'd0, err}, {31'd0, ERR_EN});
    do_access(1'b0, 3'd1, 4'hF, 32'd0, rd, ack, err, lat);
    check("unf_sticky", rd, 32'h0000_0009);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int          op;
      logic [3:0]  sel;
      logic [31:0] dat;
      op  = int'($urandom_range(0, 11));
      sel = 4'($urandom);
      dat = 32'($urandom);
      case (op)
        0, 1, 2: do_access(1'b1, 3'd0, sel, dat, rd, ack, err, lat);
        3, 4:    do_access(1'b0, 3'd0, sel | 4'h1, dat, rd, ack, err, lat);
        5:       do_access(1'b0, 3'd1, sel, dat, rd, ack, err, lat);
        6:       do_access(1'b1, 3'd2, sel, dat & 32'h0000_0103, rd, ack, err, lat);
        7:       do_access(1'b0, 3'd2, sel, dat, rd, ack, err, lat);
        8:       do_access(1'b1, 3'd3, sel, dat, rd, ack, err, lat);
        9:       do_access(1'b0, 3'd3, sel, dat, rd, ack, err, lat);
        10:      do_access(1'b0, 3'(4 + $urandom_range(0, 3)), sel, dat, rd, ack, err, lat);
        default: do_access(1'b1, 3'(4 + $urandom_range(0, 3)), sel, dat, rd, ack, err, lat);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_fifo_slave.md
WB_FIFO_SLAVE -- requirements
Module: wb_fifo_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, byte-FIFO depth (power of two, 2..128).
REQ-002 SHALL have parameter WAIT_DEFAULT, default 0, reset value of the wait-state count (0..15).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_adr_i  in  5  byte address; word select = wb_adr_i[4:2], bits [1:0] ignored.
REQ-006 SHALL have ports wb_dat_i  in  32  write data; wb_dat_o  out  32  read data.
REQ-007 SHALL have ports wb_we_i, wb_stb_i, wb_cyc_i  in  1  Wishbone classic write-enable, strobe, cycle.
REQ-008 SHALL have port wb_sel_i  in  4  byte-lane select.
REQ-009 SHALL have port wb_ack_o  out  1  registered transfer acknowledge.

Function
REQ-010 SHALL be a Wishbone classic responder; FSM states IDLE, WAIT, ACK.
REQ-011 IDLE with cyc&stb sampled high SHALL latch adr/we/sel/dat and go to WAIT if wait count > 0, else ACK.
REQ-012 WAIT SHALL decrement a counter loaded with the wait count and go to ACK when it reaches 1; ack arrives 1+N cycles after the request sample.
REQ-013 ACK SHALL drive wb_ack_o=1 and valid wb_dat_o for exactly one cycle, then return to IDLE; a still-held stb starts a new transfer only from IDLE.
REQ-014 cyc or stb low during WAIT SHALL abort to IDLE with no side effects and no ack.
REQ-015 All register side effects (push, pop, writes, flush) SHALL occur in the ACK cycle only.
REQ-016 Word 0 DATA: write with sel[0] SHALL push dat[7:0]; read SHALL return {24'b0, head} and pop when sel[0] and not empty; read when empty SHALL return 0.
REQ-017 Word 1 STATUS (read-only): [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [15:8] count; other bits 0.
REQ-018 Word 2 CTRL: [3:0] wait count (R/W, lane 0); writing 1 to bit 8 (lane 1) SHALL flush FIFO and clear both sticky bits; bit 8 reads 0.
REQ-019 Word 3 SCRATCH: 32-bit R/W, each byte written only if its sel bit is set.
REQ-020 Push when full SHALL drop the byte and set overflow; pop when empty SHALL set underflow; pointers wrap modulo DEPTH.
REQ-021 wb_dat_o SHALL be 0 whenever wb_ack_o is 0.

Reset
REQ-022 wb_rst_i SHALL force IDLE, wb_ack_o=0, wb_dat_o=0, FIFO empty, sticky bits 0, wait count=WAIT_DEFAULT, SCRATCH=0.
REQ-023 Reset asserted during WAIT or ACK SHALL cancel the transfer with no side effect; ack low the next cycle.

Configuration
REQ-024 Macro WB_FIFO_SLAVE_ERR_EN defined SHALL add port wb_err_o out 1, reset 0.
REQ-025 With it, words 4..7, push when full and pop when empty SHALL end with wb_err_o=1 for one cycle instead of ack, sticky bits still set, no FIFO change.
REQ-026 Without it, such accesses SHALL ack normally; words 4..7 read 0, writes ignored.

Structure
REQ-027 Package wb_fifo_slave_pkg SHALL hold word-address constants, FSM state encoding and STATUS/CTRL bit positions.
REQ-028 The byte FIFO SHALL be sub-module wb_fifo_slave_fifo (sync, push/pop/flush, count, full, empty).

Verification
REQ-029 Reset, read STATUS (wait=0) -> ack 1 cycle after sample, data 0x00000001.
REQ-030 Push 0x81 then 0x42, read DATA twice -> 0x81, 0x42, then STATUS empty=1.
REQ-031 CTRL wait=3, read SCRATCH after writing 0xA5A5A5A5 with sel=4'b0101 -> ack 4 cycles after sample, data 0x00A500A5.
REQ-032 Push DEPTH+1 bytes -> STATUS full=1, overflow=1, count=DEPTH; flush -> 0x00000001.
REQ-033 Drop stb mid-WAIT -> no ack, FIFO count unchanged; pulse reset during WAIT -> no ack.
REQ-034 ERR_EN build: read word 5 and pop empty -> wb_err_o=1, wb_ack_o=0; non-ERR_EN build -> ack with data 0.
